// File: rtl/divider_arbiter.sv
// Round-robin arbiter that shares one hardware divider between requesters.
// Divide-by-zero is answered locally, and a divider that never answers is aborted.
//
// state   | meaning
// S_IDLE  | no operation; pick next requester round-robin from last grant
// S_ISSUE | operands latched, waiting for divider not busy to pulse start
// S_WAIT  | waiting for divider ready, timer counting toward abort
// S_RESP  | one-cycle done pulse to the served requester

module divider_arbiter #(
  parameter int N_REQ   = 3,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] req_dividend_i,
  input  logic [N_REQ*WIDTH-1:0] req_divisor_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [WIDTH-1:0]       result_o,
  output logic                   err_o,
  output logic                   div_start_o,
  output logic [WIDTH-1:0]       div_dividend_o,
  output logic [WIDTH-1:0]       div_divisor_o,
  output logic [1:0]             div_select_o,
  input  logic                   div_busy_i,
  input  logic                   div_ready_i,
  input  logic [WIDTH-1:0]       div_quotient_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [15:0]      timer_q, timer_d;

  logic             found;
  logic [1:0]       pick;
  logic [2:0]       cand;
  logic             hit;
  logic [WIDTH-1:0] pick_dvd, pick_dvs;
  logic             timeout_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      last_q   <= 2'(N_REQ - 1);
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
    end
  end

  // Scan last+1 .. last+N_REQ (mod N_REQ); the last granted requester comes last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    hit   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_q} + 3'(k);
      if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
      hit = 1'b0;
      for (int j = 0; j < N_REQ; j++)
        if (3'(j) == cand) hit = req_i[j];
      if (!found && hit) begin
        found = 1'b1;
        pick  = cand[1:0];
      end
    end
  end

  always_comb begin
    pick_dvd = '0;
    pick_dvs = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (2'(j) == pick) begin
        pick_dvd = req_dividend_i[j*WIDTH +: WIDTH];
        pick_dvs = req_divisor_i[j*WIDTH +: WIDTH];
      end
    end
  end

  // Abort on the cycle the incremented timer would reach TIMEOUT-1.
  assign timeout_hit = ({1'b0, timer_q} + 17'd1) >= 17'(TIMEOUT - 1);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    err_d    = err_q;
    timer_d  = timer_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_d  = pick;
          last_d = pick;
          opa_d  = pick_dvd;
          opb_d  = pick_dvs;
          if (pick_dvs == '0) begin
            result_d = '1;
            err_d    = 1'b1;
            state_d  = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!div_busy_i) begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (div_ready_i) begin
          result_d = div_quotient_i;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else begin
          timer_d = timer_q + 16'd1;
          if (timeout_hit) begin
            result_d = '1;
            err_d    = 1'b1;
            state_d  = S_RESP;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o  = '0;
    done_o = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (2'(j) == sel_q) begin
        gnt_o[j]  = (state_q != S_IDLE);
        done_o[j] = (state_q == S_RESP);
      end
    end
    div_start_o    = (state_q == S_ISSUE) && !div_busy_i;
    div_dividend_o = opa_q;
    div_divisor_o  = opb_q;
    div_select_o   = sel_q;
    result_o       = result_q;
    err_o          = err_q;
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed latency scenarios plus randomized multi-requester
// traffic checked against a round-robin / arithmetic reference model.
module tb_divider_arbiter;
  localparam int N  = 3;
  localparam int W  = 16;
  localparam int TO = 64;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] req_dividend_i, req_divisor_i;
  logic [N-1:0]   gnt_o, done_o;
  logic [W-1:0]   result_o;
  logic           err_o, div_start_o;
  logic [W-1:0]   div_dividend_o, div_divisor_o;
  logic [1:0]     div_select_o;
  logic           div_busy_i, div_ready_i;
  logic [W-1:0]   div_quotient_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // divider model and traffic settings
  int         lat       = 5;
  bit         hang      = 1'b0;
  bit         rand_busy = 1'b0;
  int         rem       = 0;
  logic [W-1:0] mq;

  // reference model state
  int         m_last;
  int         ops_left [N];
  int         op_idx   [N];
  logic [W-1:0] dvd_tab [N][8];
  logic [W-1:0] dvs_tab [N][8];

  divider_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .req_dividend_i (req_dividend_i),
    .req_divisor_i  (req_divisor_i),
    .gnt_o          (gnt_o),
    .done_o         (done_o),
    .result_o       (result_o),
    .err_o          (err_o),
    .div_start_o    (div_start_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_select_o   (div_select_o),
    .div_busy_i     (div_busy_i),
    .div_ready_i    (div_ready_i),
    .div_quotient_i (div_quotient_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Divider: answers lat cycles after the start pulse unless hung; garbage otherwise.
  always @(negedge clk_i) begin
    div_ready_i    = 1'b0;
    div_quotient_i = 16'($urandom);
    if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) begin
        div_ready_i    = 1'b1;
        div_quotient_i = mq;
      end
    end
    if (div_start_o === 1'b1 && !hang) begin
      rem = lat;
      mq  = (div_divisor_o != 0) ? div_dividend_o / div_divisor_o : 16'hFFFF;
    end
  end

  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit h);
    if (b == 0 || h) return {1'b1, 16'hFFFF};
    return {1'b0, a / b};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input bit on);
    req_i[i] = on;
    req_dividend_i[i*W +: W] = a;
    req_divisor_i[i*W +: W]  = b;
  endtask

  // Drives a single request and records what the DUT did over a fixed window.
  task automatic run_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int busy_n, input int budget,
                         output int t0, output int n_start, output int t_start,
                         output int n_done, output int t_done, output logic [N-1:0] done_v,
                         output logic [W-1:0] res, output logic err, output bit stable,
                         output logic [1:0] sel);
    n_start = 0; t_start = -1; n_done = 0; t_done = -1;
    done_v = '0; res = '0; err = 1'b0; stable = 1'b1; sel = '0;
    step();
    div_busy_i = (busy_n > 0);
    set_req(idx, a, b, 1'b1);
    t0 = cyc;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_i);
      if (cyc > t0 && n_done == 0 && (div_dividend_o !== a || div_divisor_o !== b)) stable = 1'b0;
      if (div_start_o === 1'b1) begin
        n_start++;
        if (t_start < 0) begin
          t_start = cyc;
          sel = div_select_o;
        end
      end
      if (done_o !== '0) begin
        n_done++;
        if (t_done < 0) begin
          t_done = cyc; done_v = done_o; res = result_o; err = err_o;
        end
      end
      step();
      if (n_done > 0) req_i[idx] = 1'b0;
      div_busy_i = (busy_n > 0) && (cyc - t0 <= busy_n);
    end
    req_i = '0;
    div_busy_i = 1'b0;
  endtask

  // Serves all queued operations; each done is checked against the round-robin model.
  task automatic serve_all(input int budget);
    int left;
    int exp_idx;
    int j;
    bit hold [N];
    logic [N-1:0] e;
    logic [W:0] r;
    left = 0;
    for (int i = 0; i < N; i++) begin
      left += ops_left[i];
      op_idx[i] = 0;
      hold[i] = 1'b0;
    end
    for (int c = 0; c < budget && left > 0; c++) begin
      step();
      if (rand_busy) div_busy_i = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (ops_left[i] > 0 && !hold[i]) set_req(i, dvd_tab[i][op_idx[i]], dvs_tab[i][op_idx[i]], 1'b1);
        else req_i[i] = 1'b0;
        hold[i] = 1'b0;
      end
      @(negedge clk_i);
      if (done_o !== '0) begin
        exp_idx = -1;
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (exp_idx < 0 && ops_left[j] > 0) exp_idx = j;
        end
        if (exp_idx < 0) begin
          total++; bad++;
          $display("FAIL rr_extra_done: got done=%b want no done", done_o);
          left = 0;
        end else begin
          e = '0; e[exp_idx] = 1'b1;
          r = ref_op(dvd_tab[exp_idx][op_idx[exp_idx]], dvs_tab[exp_idx][op_idx[exp_idx]], 1'b0);
          total++;
          if (done_o !== e) begin
            bad++; $display("FAIL rr_order: got done=%b want %b", done_o, e);
          end
          total++;
          if (result_o !== r[W-1:0]) begin
            bad++; $display("FAIL rr_result: got %0h want %0h (req %0d)", result_o, r[W-1:0], exp_idx);
          end
          total++;
          if (err_o !== r[W]) begin
            bad++; $display("FAIL rr_err: got %b want %b (req %0d)", err_o, r[W], exp_idx);
          end
          total++;
          if (gnt_o !== e) begin
            bad++; $display("FAIL rr_gnt: got %b want %b", gnt_o, e);
          end
          ops_left[exp_idx]--;
          op_idx[exp_idx]++;
          hold[exp_idx] = 1'b1;
          m_last = exp_idx;
          left--;
        end
      end
    end
    total++;
    if (left != 0) begin
      bad++; $display("FAIL rr_budget: got %0d ops outstanding want 0", left);
    end
    step();
    req_i = '0;
    div_busy_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    total++;
    if ({gnt_o, done_o, result_o, err_o, div_start_o, div_dividend_o, div_divisor_o, div_select_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b done=%b res=%0h err=%b st=%b dvd=%0h dvs=%0h sel=%0d want all 0",
               gnt_o, done_o, result_o, err_o, div_start_o, div_dividend_o, div_divisor_o, div_select_o);
    end
    m_last = N - 1;
  endtask

  task automatic test_simultaneous();
    lat = 3;
    for (int i = 0; i < N; i++) begin
      ops_left[i] = 1;
      dvd_tab[i][0] = 16'(1000 * (i + 1));
      dvs_tab[i][0] = 16'(7 + i);
    end
    serve_all(200);
    ops_left[0] = 3; ops_left[1] = 3; ops_left[2] = 0;
    for (int k = 0; k < 3; k++) begin
      dvd_tab[0][k] = 16'($urandom); dvs_tab[0][k] = 16'($urandom_range(1, 500));
      dvd_tab[1][k] = 16'($urandom); dvs_tab[1][k] = 16'($urandom_range(1, 500));
    end
    serve_all(300);
  endtask

  task automatic test_single();
    int t0, ns, ts, nd, td; logic [N-1:0] dv; logic [W-1:0] res; logic err; bit st; logic [1:0] sel;
    lat = 5;
    run_one(0, 16'd36000, 16'd600, 0, 15, t0, ns, ts, nd, td, dv, res, err, st, sel);
    total++; if (ns != 1)      begin bad++; $display("FAIL single_starts: got %0d want 1", ns); end
    total++; if (ts != t0 + 1) begin bad++; $display("FAIL single_start_cyc: got %0d want %0d", ts - t0, 1); end
    total++; if (!st)          begin bad++; $display("FAIL single_operands: got unstable want 36000/600"); end
    total++; if (td != t0 + 7) begin bad++; $display("FAIL single_done_cyc: got %0d want 7", td - t0); end
    total++; if (nd != 1)      begin bad++; $display("FAIL single_done_cnt: got %0d want 1", nd); end
    total++; if (dv !== 3'b001) begin bad++; $display("FAIL single_done_vec: got %b want 001", dv); end
    total++; if (res !== 16'd60) begin bad++; $display("FAIL single_result: got %0d want 60", res); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", err); end
    @(negedge clk_i);
    total++; if (gnt_o !== '0) begin bad++; $display("FAIL single_gnt_after: got %b want 000", gnt_o); end
    total++; if (result_o !== 16'd60) begin bad++; $display("FAIL single_result_hold: got %0d want 60", result_o); end
    m_last = 0;
  endtask

  task automatic test_div_zero();
    int t0, ns, ts, nd, td; logic [N-1:0] dv; logic [W-1:0] res; logic err; bit st; logic [1:0] sel;
    run_one(1, 16'd1234, 16'd0, 0, 8, t0, ns, ts, nd, td, dv, res, err, st, sel);
    total++; if (ns != 0)      begin bad++; $display("FAIL dz_starts: got %0d want 0", ns); end
    total++; if (td != t0 + 1) begin bad++; $display("FAIL dz_done_cyc: got %0d want 1", td - t0); end
    total++; if (dv !== 3'b010) begin bad++; $display("FAIL dz_done_vec: got %b want 010", dv); end
    total++; if (res !== 16'hFFFF) begin bad++; $display("FAIL dz_result: got %0h want ffff", res); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL dz_err: got %b want 1", err); end
    m_last = 1;
  endtask

  task automatic test_busy();
    int t0, ns, ts, nd, td; logic [N-1:0] dv; logic [W-1:0] res; logic err; bit st; logic [1:0] sel;
    logic [W-1:0] a, b; logic [W:0] r;
    lat = 4;
    a = 16'($urandom); b = 16'($urandom_range(1, 300));
    r = ref_op(a, b, 1'b0);
    run_one(2, a, b, 10, 25, t0, ns, ts, nd, td, dv, res, err, st, sel);
    total++; if (ns != 1)       begin bad++; $display("FAIL busy_starts: got %0d want 1", ns); end
    total++; if (ts != t0 + 11) begin bad++; $display("FAIL busy_start_cyc: got %0d want 11", ts - t0); end
    total++; if (!st)           begin bad++; $display("FAIL busy_operands: got unstable want %0h/%0h", a, b); end
    total++; if (sel !== 2'd2)  begin bad++; $display("FAIL busy_select: got %0d want 2", sel); end
    total++; if (td != ts + lat + 1) begin bad++; $display("FAIL busy_done_cyc: got %0d want %0d", td - t0, 11 + lat + 1); end
    total++; if (res !== r[W-1:0] || err !== 1'b0) begin
      bad++; $display("FAIL busy_result: got %0h/%b want %0h/0", res, err, r[W-1:0]);
    end
    m_last = 2;
  endtask

  task automatic test_timeout();
    int t0, ns, ts, nd, td; logic [N-1:0] dv; logic [W-1:0] res; logic err; bit st; logic [1:0] sel;
    logic [W-1:0] a, b; logic [W:0] r;
    hang = 1'b1;
    run_one(0, 16'd5000, 16'd50, 0, 80, t0, ns, ts, nd, td, dv, res, err, st, sel);
    total++; if (ts != t0 + 1)   begin bad++; $display("FAIL to_start_cyc: got %0d want 1", ts - t0); end
    total++; if (td != ts + TO)  begin bad++; $display("FAIL to_done_cyc: got %0d want %0d", td - ts, TO); end
    total++; if (dv !== 3'b001)  begin bad++; $display("FAIL to_done_vec: got %b want 001", dv); end
    total++; if (res !== 16'hFFFF || err !== 1'b1) begin
      bad++; $display("FAIL to_result: got %0h/%b want ffff/1", res, err);
    end
    hang = 1'b0;
    lat = 3;
    a = 16'($urandom); b = 16'($urandom_range(1, 900));
    r = ref_op(a, b, 1'b0);
    run_one(1, a, b, 0, 12, t0, ns, ts, nd, td, dv, res, err, st, sel);
    total++; if (td != t0 + lat + 2) begin bad++; $display("FAIL to_next_cyc: got %0d want %0d", td - t0, lat + 2); end
    total++; if (res !== r[W-1:0] || err !== 1'b0 || dv !== 3'b010) begin
      bad++; $display("FAIL to_next_result: got %0h/%b/%b want %0h/0/010", res, err, dv, r[W-1:0]);
    end
    m_last = 1;
  endtask

  task automatic test_reset_mid();
    int nd;
    bit seen;
    lat = 20;
    step();
    set_req(1, 16'd900, 16'd30, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_i);
      if (div_start_o === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL rm_start: got no start want start"); end
    repeat (3) step();
    rst_i = 1'b1;
    req_i = '0;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    total++;
    if ({gnt_o, done_o, result_o, err_o, div_start_o, div_dividend_o, div_divisor_o, div_select_o} !== '0) begin
      bad++;
      $display("FAIL rm_outputs: got gnt=%b done=%b res=%0h err=%b st=%b dvd=%0h dvs=%0h sel=%0d want all 0",
               gnt_o, done_o, result_o, err_o, div_start_o, div_dividend_o, div_divisor_o, div_select_o);
    end
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (done_o !== '0) nd++;
    end
    total++; if (nd != 0) begin bad++; $display("FAIL rm_late_ready: got %0d done want 0", nd); end
    m_last = N - 1;
    lat = 3;
    ops_left[0] = 1; ops_left[1] = 0; ops_left[2] = 1;
    dvd_tab[0][0] = 16'd4242; dvs_tab[0][0] = 16'd21;
    dvd_tab[2][0] = 16'd777;  dvs_tab[2][0] = 16'd7;
    serve_all(100);
  endtask

  task automatic test_random();
    rand_busy = 1'b1;
    for (int round = 0; round < 6; round++) begin
      lat = $urandom_range(1, 8);
      for (int i = 0; i < N; i++) begin
        ops_left[i] = $urandom_range(0, 4);
        for (int k = 0; k < 8; k++) begin
          dvd_tab[i][k] = 16'($urandom);
          dvs_tab[i][k] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 400));
        end
      end
      serve_all(1500);
    end
    rand_busy = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    req_i = '0;
    req_dividend_i = '0;
    req_divisor_i = '0;
    div_busy_i = 1'b0;
    test_reset();
    test_simultaneous();
    test_single();
    test_div_zero();
    test_busy();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
